// File: rtl/object_report_reader.sv
// Purpose: after a frame, walks label ids 1..num_labels-1 on the labeler's object-query port,
//          drops merged (non-root) and undersized objects, and streams one record per surviving object.
// Latency: each id is held on obj_id for READ_LATENCY+1 cycles before its query data is sampled.
// Backpressure: a pending record holds out_* and obj_id stable until out_ready; the scan stalls meanwhile.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, num_labels     scan request pulse and the labeler's next-free label (sampled on accepted start)
//   obj_id                query address driven to the labeler
//   obj_root/area/x/y     query results, valid READ_LATENCY cycles after obj_id changes
//   busy                  high while scanning (READ/EMIT)
//   out_valid/out_ready   record handshake; out_id/out_area/out_x/out_y carry the record
//   done                  one-cycle pulse when the scan completes
//   obj_count             number of records emitted in the last/current scan (saturating)
module object_report_reader #(
    parameter int LBL_WIDTH    = 8,
    parameter int LOC_SIZE     = 16,
    parameter int READ_LATENCY = 2,
    parameter int MIN_AREA     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LBL_WIDTH-1:0] num_labels,
    output logic [LBL_WIDTH-1:0] obj_id,
    input  logic [LBL_WIDTH-1:0] obj_root,
    input  logic [LOC_SIZE-1:0]  obj_area,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LBL_WIDTH-1:0] out_id,
    output logic [LOC_SIZE-1:0]  out_area,
    output logic [LOC_SIZE-1:0]  out_x,
    output logic [LOC_SIZE-1:0]  out_y,
    output logic                 done,
    output logic [LBL_WIDTH-1:0] obj_count
);

    // Sized so that READ_LATENCY itself is representable, even when it is 0.
    localparam int CNT_W = $clog2(READ_LATENCY + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LBL_WIDTH-1:0] last;
    logic [CNT_W-1:0]     wait_cnt;

    logic                 take_start;
    logic                 load_rec;
    logic                 xfer;
    logic                 advance;
    logic                 keep;
    logic                 at_last_id;
    logic                 start_empty;

    assign keep        = (obj_root == obj_id) && (obj_area >= LOC_SIZE'(MIN_AREA));
    assign at_last_id  = (obj_id == last - LBL_WIDTH'(1));
    assign start_empty = (num_labels <= LBL_WIDTH'(1));

    // Next-state and control strobes.
    always_comb begin
        state_nxt  = state;
        take_start = 1'b0;
        load_rec   = 1'b0;
        xfer       = 1'b0;
        advance    = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_nxt  = start_empty ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (wait_cnt == CNT_LAST) begin
                    if (keep) begin
                        load_rec  = 1'b1;
                        state_nxt = S_EMIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    xfer    = 1'b1;
                    advance = 1'b1;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Advancing past the last id ends the scan; otherwise the next id is read.
        if (advance) begin
            state_nxt = at_last_id ? S_FINISH : S_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            last      <= '0;
            wait_cnt  <= '0;
            obj_id    <= '0;
            out_id    <= '0;
            out_area  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            obj_count <= '0;
        end else begin
            state <= state_nxt;

            if (take_start) begin
                last      <= num_labels;
                obj_count <= '0;
                wait_cnt  <= '0;
                obj_id    <= start_empty ? '0 : LBL_WIDTH'(1);
            end

            if (state == S_READ && wait_cnt != CNT_LAST) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (load_rec) begin
                out_id   <= obj_id;
                out_area <= obj_area;
                out_x    <= obj_x;
                out_y    <= obj_y;
            end

            if (xfer && obj_count != '1) begin
                obj_count <= obj_count + LBL_WIDTH'(1);
            end

            // obj_id stops at last-1; it never wraps.
            if (advance && !at_last_id) begin
                obj_id   <= obj_id + LBL_WIDTH'(1);
                wait_cnt <= '0;
            end

            if (state == S_FINISH) begin
                obj_id <= '0;
            end
        end
    end

endmodule
